// File: rtl/dmix_dcm_pkg.sv
// dmix_dcm_pkg: state encoding, default timing constants and a width helper
// shared by the DCM reset/lock sequencer and its interface.
package dmix_dcm_pkg;

   typedef enum logic [2:0] {
      ST_HOLD   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_FAIL   = 3'd4
   } dcm_state_t;

   localparam int DEF_RST_CYCLES    = 8;
   localparam int DEF_LOCK_TIMEOUT  = 262144;
   localparam int DEF_SETTLE_CYCLES = 1024;
   localparam int DEF_MAX_RETRIES   = 4;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/dmix_dcm_ctrl_if.sv
// dmix_dcm_ctrl_if: DCM status inputs, sequencing control and the reset/ready
// outputs of the lock sequencer, bundled as one port.
interface dmix_dcm_ctrl_if
   import dmix_dcm_pkg::*;
#(
   parameter int MAX_RETRIES = DEF_MAX_RETRIES
);
   localparam int RW = cnt_width(MAX_RETRIES);

   logic          dcm_locked;
   logic          dcm_clkin_stopped;
   logic          restart;
   logic          rst_dcm;
   logic          dcm_ready;
   logic          rst_sys;
   logic [RW-1:0] retry_cnt;
   logic          fail;
   logic [2:0]    state;

   // Side that owns the DCM status and requests re-sequencing.
   modport master (
      output dcm_locked, dcm_clkin_stopped, restart,
      input  rst_dcm, dcm_ready, rst_sys, retry_cnt, fail, state
   );

   // The sequencer itself.
   modport slave (
      input  dcm_locked, dcm_clkin_stopped, restart,
      output rst_dcm, dcm_ready, rst_sys, retry_cnt, fail, state
   );
endinterface

// File: rtl/dmix_sync2.sv
// dmix_sync2: two-flop synchronizer for a single asynchronous status bit.
module dmix_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   // Two back-to-back flops; both clear to 0 on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/dmix_dcm_ctrl.sv
// dmix_dcm_ctrl: pulses the DCM reset, waits for a stable lock, releases the
// system reset, and re-sequences on loss of lock or input-clock stop. After
// MAX_RETRIES consecutive failures it parks in a sticky FAIL state.
module dmix_dcm_ctrl
   import dmix_dcm_pkg::*;
#(
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
   input  logic           clk245760,
   input  logic           rst,
   dmix_dcm_ctrl_if.slave bus
);
   // The cycle counter is shared: it times the DCM reset pulse in HOLD and
   // the run of consecutive locked cycles in SETTLE.
   localparam int CW = cnt_width((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES);
   localparam int TW = cnt_width(LOCK_TIMEOUT);
   localparam int RW = cnt_width(MAX_RETRIES);

   localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRIES - 1);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

   logic          lk_s;
   logic          stp_s;
   dcm_state_t    state_r, state_nxt_s;
   logic [CW-1:0] cnt_r, cnt_nxt_s;
   logic [TW-1:0] tmo_r, tmo_nxt_s;
   logic [RW-1:0] retry_r, retry_nxt_s;
   logic          fail_r, fail_nxt_s;
   logic          failure_s;
   logic          rst_dcm_r, dcm_ready_r, rst_sys_r;

   dmix_sync2 u_sync_lk  (.clk(clk245760), .rst(rst), .d(bus.dcm_locked),        .q(lk_s));
   dmix_sync2 u_sync_stp (.clk(clk245760), .rst(rst), .d(bus.dcm_clkin_stopped), .q(stp_s));

   // Next-state and counter updates; restart outranks everything, and a
   // completed settle outranks a timeout landing on the same cycle.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      tmo_nxt_s   = tmo_r;
      retry_nxt_s = retry_r;
      fail_nxt_s  = fail_r;
      failure_s   = 1'b0;
      if (bus.restart) begin
         state_nxt_s = ST_HOLD;
         cnt_nxt_s   = {CW{1'b0}};
         tmo_nxt_s   = {TW{1'b0}};
         if (state_r == ST_FAIL) begin
            retry_nxt_s = {RW{1'b0}};
            fail_nxt_s  = 1'b0;
         end else begin
            retry_nxt_s = retry_r;
         end
      end else begin
         case (state_r)
            ST_HOLD: begin
               if (cnt_r == RST_LAST) begin
                  state_nxt_s = ST_WAIT;
                  cnt_nxt_s   = {CW{1'b0}};
                  tmo_nxt_s   = {TW{1'b0}};
               end else begin
                  cnt_nxt_s = cnt_r + 1'b1;
               end
            end
            ST_WAIT: begin
               if (tmo_r == TMO_LAST) begin
                  failure_s = 1'b1;
               end else if (lk_s) begin
                  state_nxt_s = ST_SETTLE;
                  cnt_nxt_s   = {CW{1'b0}};
                  tmo_nxt_s   = tmo_r + 1'b1;
               end else begin
                  tmo_nxt_s = tmo_r + 1'b1;
               end
            end
            ST_SETTLE: begin
               if (lk_s && (cnt_r == SETTLE_LAST)) begin
                  state_nxt_s = ST_RUN;
                  cnt_nxt_s   = {CW{1'b0}};
                  tmo_nxt_s   = {TW{1'b0}};
                  retry_nxt_s = {RW{1'b0}};
               end else if (tmo_r == TMO_LAST) begin
                  failure_s = 1'b1;
               end else if (!lk_s) begin
                  state_nxt_s = ST_WAIT;
                  cnt_nxt_s   = {CW{1'b0}};
                  tmo_nxt_s   = tmo_r + 1'b1;
               end else begin
                  cnt_nxt_s = cnt_r + 1'b1;
                  tmo_nxt_s = tmo_r + 1'b1;
               end
            end
            ST_RUN: begin
               if (!lk_s || stp_s) begin
                  failure_s = 1'b1;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_FAIL: begin
               state_nxt_s = ST_FAIL;
            end
            default: begin
               state_nxt_s = ST_HOLD;
               cnt_nxt_s   = {CW{1'b0}};
               tmo_nxt_s   = {TW{1'b0}};
            end
         endcase
         if (failure_s) begin
            cnt_nxt_s = {CW{1'b0}};
            tmo_nxt_s = {TW{1'b0}};
            if (retry_r >= RETRY_LAST) begin
               state_nxt_s = ST_FAIL;
               retry_nxt_s = RETRY_MAX;
               fail_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = ST_HOLD;
               retry_nxt_s = retry_r + 1'b1;
            end
         end else begin
            fail_nxt_s = fail_r;
         end
      end
   end

   // State, counters and registered outputs; rst_dcm/dcm_ready follow the
   // state being entered, rst_sys trails dcm_ready by one cycle.
   always_ff @(posedge clk245760 or posedge rst) begin
      if (rst) begin
         state_r     <= ST_HOLD;
         cnt_r       <= {CW{1'b0}};
         tmo_r       <= {TW{1'b0}};
         retry_r     <= {RW{1'b0}};
         fail_r      <= 1'b0;
         rst_dcm_r   <= 1'b1;
         dcm_ready_r <= 1'b0;
         rst_sys_r   <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         tmo_r       <= tmo_nxt_s;
         retry_r     <= retry_nxt_s;
         fail_r      <= fail_nxt_s;
         rst_dcm_r   <= (state_nxt_s == ST_HOLD) || (state_nxt_s == ST_FAIL);
         dcm_ready_r <= (state_nxt_s == ST_RUN);
         rst_sys_r   <= ~dcm_ready_r;
      end
   end

   assign bus.rst_dcm   = rst_dcm_r;
   assign bus.dcm_ready = dcm_ready_r;
   assign bus.rst_sys   = rst_sys_r;
   assign bus.retry_cnt = retry_r;
   assign bus.fail      = fail_r;
   assign bus.state     = state_r;
endmodule

// File: tb/tb_dmix_dcm_ctrl.sv
// tb_dmix_dcm_ctrl: table-driven lock scenarios, directed corner sequences and
// a randomized run, every cycle compared against a timestamp-based model.
module tb_dmix_dcm_ctrl;
   import dmix_dcm_pkg::*;

   localparam int RSTC = 8;
   localparam int TMO  = 200;
   localparam int SETC = 16;
   localparam int MAXR = 4;
   localparam int RW   = cnt_width(MAXR);

   localparam int M_HOLD = 0, M_WAIT = 1, M_SETTLE = 2, M_RUN = 3, M_FAIL = 4;

   typedef struct {
      string name;
      int    lock_delay;
      bit    exp_ready;
      int    exp_lat;
      int    exp_retry;
   } vec_t;

   logic clk245760 = 1'b0;
   logic rst = 1'b1;

   dmix_dcm_ctrl_if #(.MAX_RETRIES(MAXR)) bus ();

   dmix_dcm_ctrl #(
      .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .SETTLE_CYCLES(SETC), .MAX_RETRIES(MAXR)
   ) dut (
      .clk245760(clk245760),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk245760 = ~clk245760;

   int n_vec = 0;
   int n_bad = 0;
   int ecount = 0;
   vec_t tbl [4];

   // reference model: phase, timestamps of phase entry, locked-run length
   int m_mode, m_hold_at, m_wait_at, m_ones, m_retry;
   bit m_fail, m_prev_ready;
   bit lk_p1, lk_p2, st_p1, st_p2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
      end
   endtask

   task automatic model_reset();
      m_mode = M_HOLD; m_hold_at = ecount; m_wait_at = 0; m_ones = 0;
      m_retry = 0; m_fail = 1'b0; m_prev_ready = 1'b0;
      lk_p1 = 1'b0; lk_p2 = 1'b0; st_p1 = 1'b0; st_p2 = 1'b0;
   endtask

   task automatic model_update();
      bit lk, st, fault;
      lk = lk_p2; st = st_p2;
      lk_p2 = lk_p1; lk_p1 = bus.dcm_locked;
      st_p2 = st_p1; st_p1 = bus.dcm_clkin_stopped;
      m_prev_ready = (m_mode == M_RUN);
      fault = 1'b0;
      if (bus.restart) begin
         if (m_mode == M_FAIL) begin
            m_retry = 0; m_fail = 1'b0;
         end
         m_mode = M_HOLD; m_hold_at = ecount;
      end else begin
         case (m_mode)
            M_HOLD: if (ecount - m_hold_at == RSTC) begin
               m_mode = M_WAIT; m_wait_at = ecount; m_ones = 0;
            end
            M_WAIT, M_SETTLE: begin
               m_ones = lk ? m_ones + 1 : 0;
               if (m_ones == SETC + 1) begin
                  m_mode = M_RUN; m_retry = 0;
               end else if (ecount - m_wait_at == TMO) fault = 1'b1;
               else m_mode = (m_ones > 0) ? M_SETTLE : M_WAIT;
            end
            M_RUN: if (!lk || st) fault = 1'b1;
            default: ;
         endcase
         if (fault) begin
            if (m_retry + 1 >= MAXR) begin
               m_mode = M_FAIL; m_retry = MAXR; m_fail = 1'b1;
            end else begin
               m_retry++; m_mode = M_HOLD; m_hold_at = ecount;
            end
         end
      end
   endtask

   task automatic check_outputs();
      logic [5+RW:0] act, exp;
      act = {bus.state, bus.rst_dcm, bus.dcm_ready, bus.rst_sys, bus.retry_cnt, bus.fail};
      exp = {3'(m_mode), (m_mode == M_HOLD) || (m_mode == M_FAIL), m_mode == M_RUN,
             ~m_prev_ready, RW'(m_retry), m_fail};
      chk("model {state,rst_dcm,ready,rst_sys,retry,fail}", 32'(act), 32'(exp));
   endtask

   task automatic step();
      @(posedge clk245760);
      ecount++;
      if (rst) model_reset();
      else model_update();
      @(negedge clk245760);
      check_outputs();
   endtask

   task automatic apply_reset();
      bus.dcm_clkin_stopped = 1'b0;
      bus.restart = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic logic pick(input int which);
      case (which)
         0:       return bus.rst_dcm;
         1:       return bus.dcm_ready;
         2:       return bus.fail;
         default: return (bus.state == 3'd2);
      endcase
   endfunction

   task automatic wait_until(input int which, input logic val, input int limit, output int n);
      n = 0;
      while (pick(which) !== val && n < limit) begin
         step();
         n++;
      end
      chk($sformatf("wait_sig%0d", which), 32'(pick(which)), 32'(val));
   endtask

   task automatic count_rst_dcm(output int n);
      n = bus.rst_dcm ? 1 : 0;
      while (bus.rst_dcm && n < 50) begin
         step();
         if (bus.rst_dcm) n++;
      end
   endtask

   initial begin
      int n, c, burst, stp_left;
      tbl[0] = '{"clean_50",          50,  1'b1, 19, 0};
      tbl[1] = '{"lock_immediate",    0,   1'b1, 19, 0};
      tbl[2] = '{"settle_at_timeout", 181, 1'b1, 19, 0};
      tbl[3] = '{"lock_too_late",     182, 1'b0, 18, 1};

      bus.dcm_locked = 1'b0;
      bus.dcm_clkin_stopped = 1'b0;
      bus.restart = 1'b0;
      model_reset();
      apply_reset();

      // table: lock arrives d cycles after rst_dcm falls
      for (int r = 0; r < 4; r++) begin
         bus.dcm_locked = 1'b0;
         apply_reset();
         count_rst_dcm(n);
         chk({tbl[r].name, "_hold_len"}, n, RSTC);
         repeat (tbl[r].lock_delay) step();
         bus.dcm_locked = 1'b1;
         n = 0;
         do begin
            step();
            n++;
         end while (!bus.dcm_ready && !bus.rst_dcm && n < 300);
         chk({tbl[r].name, "_latency"}, n, tbl[r].exp_lat);
         chk({tbl[r].name, "_ready"}, 32'(bus.dcm_ready), 32'(tbl[r].exp_ready));
         chk({tbl[r].name, "_retry"}, 32'(bus.retry_cnt), tbl[r].exp_retry);
         if (tbl[r].exp_ready) begin
            step();
            chk({tbl[r].name, "_rst_sys"}, 32'(bus.rst_sys), 0);
         end
      end

      // loss of lock in RUN, then relock; then input clock stop in RUN
      bus.dcm_locked = 1'b1;
      apply_reset();
      wait_until(1, 1'b1, 100, n);
      bus.dcm_locked = 1'b0;
      wait_until(1, 1'b0, 10, n);
      chk("loss_latency", n, 3);
      chk("loss_rst_dcm", 32'(bus.rst_dcm), 1);
      count_rst_dcm(n);
      chk("loss_hold_len", n, RSTC);
      chk("loss_retry", 32'(bus.retry_cnt), 1);
      bus.dcm_locked = 1'b1;
      wait_until(1, 1'b1, 100, n);
      chk("relock_retry", 32'(bus.retry_cnt), 0);
      bus.dcm_clkin_stopped = 1'b1;
      wait_until(1, 1'b0, 10, n);
      chk("stop_latency", n, 3);
      bus.dcm_clkin_stopped = 1'b0;
      chk("stop_retry", 32'(bus.retry_cnt), 1);
      wait_until(1, 1'b1, 100, n);

      // restart on the same edge as a RUN loss
      bus.dcm_locked = 1'b0;
      step();
      step();
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
      chk("restart_vs_loss_state", 32'(bus.state), M_HOLD);
      chk("restart_vs_loss_retry", 32'(bus.retry_cnt), 0);

      // chattering lock never settles: timeout after TMO cycles
      apply_reset();
      wait_until(0, 1'b0, 20, n);
      c = 0;
      do begin
         if (c % 10 == 9) bus.dcm_locked = ~bus.dcm_locked;
         step();
         c++;
      end while (!bus.rst_dcm && c < 300);
      chk("chatter_timeout", c, TMO);
      chk("chatter_retry", 32'(bus.retry_cnt), 1);

      // lock held low: retries climb to FAIL, restart clears it
      bus.dcm_locked = 1'b0;
      apply_reset();
      for (int i = 1; i <= 3; i++) begin
         wait_until(0, 1'b0, 20, n);
         wait_until(0, 1'b1, 250, n);
         chk("retry_step", 32'(bus.retry_cnt), i);
      end
      wait_until(0, 1'b0, 20, n);
      wait_until(2, 1'b1, 250, n);
      chk("fail_state", 32'(bus.state), M_FAIL);
      chk("fail_rst_dcm", 32'(bus.rst_dcm), 1);
      chk("fail_retry", 32'(bus.retry_cnt), MAXR);
      repeat (20) step();
      chk("fail_sticky", 32'(bus.fail), 1);
      bus.restart = 1'b1;
      step();
      bus.restart = 1'b0;
      chk("restart_fail_state", 32'(bus.state), M_HOLD);
      chk("restart_fail_flag", 32'(bus.fail), 0);
      chk("restart_fail_retry", 32'(bus.retry_cnt), 0);

      // asynchronous reset in the middle of SETTLE
      bus.dcm_locked = 1'b1;
      apply_reset();
      wait_until(3, 1'b1, 40, n);
      repeat (3) step();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      chk("async_rst_dcm", 32'(bus.rst_dcm), 1);
      step();
      step();
      rst = 1'b0;
      count_rst_dcm(n);
      chk("after_async_hold_len", n, RSTC);
      wait_until(1, 1'b1, 100, n);

      // randomized lock/stop/restart activity
      burst = 0;
      stp_left = 0;
      for (int k = 0; k < 3000; k++) begin
         if (burst == 0) begin
            bus.dcm_locked = ($urandom_range(0, 3) != 0);
            burst = bus.dcm_locked ? int'($urandom_range(5, 150)) : int'($urandom_range(1, 40));
         end
         burst--;
         if (stp_left > 0) stp_left--;
         else if ($urandom_range(0, 199) == 0) stp_left = $urandom_range(1, 5);
         bus.dcm_clkin_stopped = (stp_left > 0);
         bus.restart = ($urandom_range(0, 399) == 0);
         step();
      end
      bus.restart = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/dmix_dcm_ctrl.md
# dmix_dcm_ctrl

Reset and lock sequencer for the dmix clock generator. Runs on the free-running pad clock `clk245760`, pulses the DCM reset, waits for lock, confirms lock is stable, then releases the system reset for the 24.576/49.152/98.304 MHz domains. It watches for loss of lock or input-clock stop, re-sequences automatically, and latches a sticky failure after repeated unsuccessful attempts.

## Interface
- `RST_CYCLES`, 8: cycles `rst_dcm` is held high per attempt (minimum 3).
- `LOCK_TIMEOUT`, 262144: maximum cycles from `rst_dcm` release to stable lock (about 10.7 ms).
- `SETTLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before declaring ready.
- `MAX_RETRIES`, 4: consecutive failures before entering FAIL.

- `clk245760` in 1: pad clock, free-running; the only clock.
- `rst` in 1: asynchronous, active-high.
- `dcm_locked` in 1: DCM LOCKED output; asynchronous to this block.
- `dcm_clkin_stopped` in 1: DCM STATUS[1]; asynchronous.
- `restart` in 1: single-cycle request to re-sequence; not counted as a failure.
- `rst_dcm` out 1: DCM RST.
- `dcm_ready` out 1: clocks valid.
- `rst_sys` out 1: system reset; equals registered `~dcm_ready`.
- `retry_cnt` out clog2(MAX_RETRIES+1): consecutive failure count.
- `fail` out 1: sticky failure flag.
- `state` out 3: current FSM state, for debug.

## Operation
- `dcm_locked` and `dcm_clkin_stopped` pass through two-flop synchronizers (`lk_s`, `stp_s`). Every decision below uses the synchronized values.
- **HOLD**: `rst_dcm`=1 and the cycle counter counts up. After `RST_CYCLES` cycles the block clears the counter and enters WAIT.
- **WAIT**: `rst_dcm`=0 and the timeout counter runs. When `lk_s`=1 the block enters SETTLE.
- **SETTLE**: the settle counter counts consecutive `lk_s`=1 cycles.
  - When the count reaches `SETTLE_CYCLES` the block enters RUN.
  - If `lk_s`=0 the block returns to WAIT. The settle counter clears; the timeout counter keeps running.
- **Timeout**: if the timeout counter reaches `LOCK_TIMEOUT` while in WAIT or SETTLE, this is a failure. The block goes to HOLD with `retry_cnt`+1.
- **RUN**: `dcm_ready`=1 and `retry_cnt` is cleared on entry. If `lk_s`=0 or `stp_s`=1, this is a failure. The block goes to HOLD with `retry_cnt`+1.
- **Failure limit**: if a failure would make `retry_cnt` equal `MAX_RETRIES`, the block enters FAIL instead of HOLD.
- **FAIL**: `rst_dcm`=1, `fail`=1, `dcm_ready`=0. The state is sticky; only `rst` or `restart` leaves it.
- **restart** (any state): the block goes to HOLD with counters cleared. `restart` out of FAIL also clears `retry_cnt` and `fail`. `restart` from any other state leaves `retry_cnt` unchanged.
- **Priority**, highest first:
  1. `rst`
  2. `restart`
  3. settle-complete (beats a timeout in the same cycle)
  4. failure
- `retry_cnt` saturates at `MAX_RETRIES`.

## Timing
- Reset values, while `rst` is asserted: state=HOLD, `rst_dcm`=1, `dcm_ready`=0, `rst_sys`=1, `retry_cnt`=0, `fail`=0, synchronizers 0.
- `rst_dcm` is high for exactly `RST_CYCLES` rising edges after `rst` deasserts, or after entry to HOLD.
- Lock-to-ready latency:
  - 2 cycles of synchronizer delay, plus 1 cycle for WAIT→SETTLE, plus `SETTLE_CYCLES` cycles.
  - `dcm_ready` rises on the edge that enters RUN.
  - `rst_sys` falls one cycle after `dcm_ready` rises.
- Loss-to-unready latency:
  - 2 cycles of synchronizer delay, then `dcm_ready` falls on the next edge.
  - `rst_dcm` rises on that same edge.
  - `rst_sys` rises one cycle later.
- All outputs are registered; none is combinational from any input.

## Structure
- Package `dmix_dcm_pkg` holds:
  - the state encoding: HOLD=0, WAIT=1, SETTLE=2, RUN=3, FAIL=4;
  - the default parameter constants;
  - a `clog2`-based width helper.
- Sub-module `dmix_sync2`: two-flop synchronizer, asynchronous active-high reset to 0. Instantiated twice.
- The counters are the cycle/settle counter, the timeout counter and `retry_cnt`, with widths derived from the parameters. Use reduced parameters in simulation.

## Test plan
Use `RST_CYCLES`=8, `LOCK_TIMEOUT`=200, `SETTLE_CYCLES`=16, `MAX_RETRIES`=4.
- **Clean lock**: `dcm_locked` rises 50 cycles after `rst_dcm` falls → `rst_dcm` high exactly 8 cycles; `dcm_ready`=1 exactly 2+1+16 cycles after the lock edge; `rst_sys` falls 1 cycle later; `retry_cnt`=0.
- **Chattering lock**: `dcm_locked` toggles every 10 cycles → SETTLE never completes; timeout at 200 cycles → HOLD with `retry_cnt`=1.
- **Repeated failure**: `dcm_locked` held low → `retry_cnt` steps 1, 2, 3, then state=FAIL and `fail`=1 with `rst_dcm` high. Then `restart` pulse → HOLD, `fail`=0, `retry_cnt`=0.
- **Loss in RUN**: drop `dcm_locked` (or raise `dcm_clkin_stopped`) in RUN → `dcm_ready` falls 3 edges later, `rst_dcm` high for 8 cycles, `retry_cnt`=1. Relock → RUN and `retry_cnt`=0.
- **Simultaneous events**: `restart` in the same cycle as a RUN loss → HOLD with `retry_cnt` unchanged. Settle-complete in the same cycle as timeout → RUN.
- **Asynchronous reset mid-SETTLE**: assert `rst` between edges → outputs take their reset values immediately; after release the sequence restarts from HOLD.
